spi_mem_bridge: RTL and testbench
=================================

# spi_mem_bridge

CPU-side memory adapter placed directly upstream of the SPI SRAM master. It accepts single load/store requests from the RISC-V core's data port and converts the RISC-V little-endian byte/half/word view into the SPI master's MSB-first, sequential-byte format. It drives and holds the master's request, address, data, byte-mask and write inputs, waits for completion, then returns formatted read data with a one-cycle ready pulse.

## Interface
- CS_GAP_CYCLES, default 2: minimum clk cycles `spi_req` stays high between two SPI transactions (deselect time); legal range 1..15.
- clk  in  1  system clock, same clock as the SPI master
- reset  in  1  synchronous, active-high reset
- mem_req  in  1  request; held high until `mem_ready`
- mem_we  in  1  1 = store, 0 = load
- mem_addr  in  24  byte address
- mem_wdata  in  32  store data, little-endian, right-aligned
- mem_size  in  2  00 byte, 01 half, 10 word, 11 treated as word
- mem_unsigned  in  1  1 = zero-extend loads, 0 = sign-extend
- mem_rdata  out  32  load result, valid with `mem_ready`
- mem_ready  out  1  single-cycle completion pulse
- mem_err  out  1  misaligned-access flag, valid with `mem_ready`
- spi_req  out  1  to master `req`; 1 holds master idle, 0 runs a transaction
- spi_addr  out  24  to master `addr`
- spi_data_in  out  32  to master `data_in`
- spi_byte_mask  out  2  to master `byte_mask`: 00 = 1 byte, 01 = 2 bytes, 10 = 4 bytes
- spi_write  out  1  to master `write`
- spi_data_out  in  32  from master `data_out`
- spi_busy  in  1  from master `busy`
- spi_valid  in  1  from master `valid`

## Operation
- FSM states IDLE, WAIT_VALID, GAP.
- IDLE: `spi_req`=1. When `mem_req`=1, latch addr, size, we, unsigned and the formatted write data into the spi_* registers, drive `spi_req`<=0, go to WAIT_VALID.
- WAIT_VALID: all spi_* outputs are held stable because the master samples addr/data while shifting. When `spi_valid`=1:
  - capture the formatted read result;
  - drive `spi_req`<=1 and `mem_ready`<=1 for one cycle;
  - load the gap counter with CS_GAP_CYCLES-1;
  - go to GAP.
- GAP: the counter decrements only while `spi_valid`=0 and `spi_busy`=0. Go to IDLE when it reaches 0. A new `mem_req` is accepted only in IDLE.
- Write format:
  - byte: `{wdata[7:0],24'h0}`
  - half: `{wdata[7:0],wdata[15:8],16'h0}`
  - word: `{wdata[7:0],wdata[15:8],wdata[23:16],wdata[31:24]}`
- Read format, with d = `spi_data_out`:
  - byte: d[31:24], extended
  - half: `{d[23:16],d[31:24]}`, extended
  - word: full byte swap of d
- Extension: zero-extend if `mem_unsigned`=1, otherwise sign-extend.
- For stores, `mem_rdata` is 0 at `mem_ready`.
- Reset values: `spi_req`=1; `mem_ready`, `mem_err`, `mem_rdata`, `spi_addr`, `spi_data_in`, `spi_byte_mask`, `spi_write` all 0; state IDLE.
- Reset mid-transaction: return to IDLE with `spi_req`=1 next cycle (this forces the master idle). No `mem_ready` is issued.
- `mem_req` dropped early is a protocol violation. The transaction completes anyway and still pulses `mem_ready`.

## Timing
- `spi_req` falls one cycle after `mem_req` is sampled in IDLE.
- `mem_ready` rises one cycle after `spi_valid` is first sampled high, and lasts exactly one cycle.
- `spi_req` stays high for at least CS_GAP_CYCLES cycles after `spi_valid` has dropped.
- Minimum IDLE-to-next-launch spacing is therefore CS_GAP_CYCLES+1 cycles after `mem_ready`.
- No combinational path exists from any input to any output.

## Configuration
- SPI_MEM_MISALIGN_TRAP_EN defined:
  - half with addr[0]≠0, or word with addr[1:0]≠0, is never launched;
  - `spi_req` stays 1;
  - next cycle `mem_ready`=1, `mem_err`=1, `mem_rdata`=0;
  - the FSM stays in IDLE.
- SPI_MEM_MISALIGN_TRAP_EN undefined: every access is forwarded unchanged, because SRAM sequential mode crosses word boundaries. `mem_err` is tied to 0.

## Structure
- Package `spi_mem_pkg` holds:
  - the `mem_size_t` enum;
  - the FSM state enum;
  - byte-mask constants SPI_MASK_1B=2'b00, SPI_MASK_2B=2'b01, SPI_MASK_4B=2'b10.
- One combinational sub-module `spi_mem_lane_fmt` does write byte-swap/placement and read extract/extend. It is instantiated once and shared by both directions.
- The FSM, gap counter and registers stay in `spi_mem_bridge`.

## Test plan
- SW 0x11223344 @0x000100 -> `spi_data_in`=0x44332211, `spi_byte_mask`=10, `spi_write`=1; `mem_ready` one cycle after `spi_valid`.
- LB signed, `spi_data_out`=0x80AABBCC -> `mem_rdata`=0xFFFFFF80, `spi_byte_mask`=00.
- LHU, `spi_data_out`=0x3412FFFF -> `mem_rdata`=0x00001234; LW same data -> 0xFFFF1234.
- Back-to-back requests with CS_GAP_CYCLES=3 -> `spi_req` high ≥3 cycles after `spi_valid` falls, second launch only afterwards.
- Reset asserted in WAIT_VALID -> `spi_req`=1 next cycle, no `mem_ready`, next request runs normally.
- LW @0x000102: with macro -> `mem_err`=1 pulse, `spi_req` never drops; without macro -> forwarded, `spi_addr`=0x000102.

Source files
------------

// File: rtl/spi_mem_pkg.sv
// Shared types and constants for the CPU-to-SPI-SRAM memory bridge.
package spi_mem_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE     = 2'b00,
        SIZE_HALF     = 2'b01,
        SIZE_WORD     = 2'b10,
        SIZE_WORD_ALT = 2'b11
    } mem_size_t;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_VALID = 2'd1,
        GAP        = 2'd2
    } bridge_state_t;

    localparam logic [1:0] SPI_MASK_1B = 2'b00;
    localparam logic [1:0] SPI_MASK_2B = 2'b01;
    localparam logic [1:0] SPI_MASK_4B = 2'b10;

    function automatic logic [1:0] size_to_mask(input mem_size_t size);
        case (size)
            SIZE_BYTE: return SPI_MASK_1B;
            SIZE_HALF: return SPI_MASK_2B;
            default:   return SPI_MASK_4B;
        endcase
    endfunction

    function automatic logic is_misaligned(input mem_size_t size, input logic [1:0] addr_lo);
        case (size)
            SIZE_BYTE: return 1'b0;
            SIZE_HALF: return addr_lo[0];
            default:   return |addr_lo;
        endcase
    endfunction

endpackage

// File: rtl/spi_mem_lane_fmt.sv
// Byte-lane formatter: little-endian CPU view <-> MSB-first sequential SPI bytes.
// Shared by the store path (placement) and the load path (extract and extend).
module spi_mem_lane_fmt
    import spi_mem_pkg::*;
(
    input  mem_size_t   size,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    input  logic [31:0] spi_rdata,
    output logic [31:0] spi_wdata,
    output logic [31:0] rdata
);

    logic sign_byte;
    logic sign_half;

    assign sign_byte = ~is_unsigned & spi_rdata[31];
    assign sign_half = ~is_unsigned & spi_rdata[23];

    always_comb begin
        spi_wdata = {wdata[7:0], wdata[15:8], wdata[23:16], wdata[31:24]};
        rdata     = {spi_rdata[7:0], spi_rdata[15:8], spi_rdata[23:16], spi_rdata[31:24]};
        case (size)
            SIZE_BYTE: begin
                spi_wdata = {wdata[7:0], 24'h0};
                rdata     = {{24{sign_byte}}, spi_rdata[31:24]};
            end
            SIZE_HALF: begin
                spi_wdata = {wdata[7:0], wdata[15:8], 16'h0};
                rdata     = {{16{sign_half}}, spi_rdata[23:16], spi_rdata[31:24]};
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/spi_mem_bridge.sv
// Single-request load/store adapter in front of the SPI SRAM master.
// Define SPI_MEM_MISALIGN_TRAP_EN to reject misaligned half/word accesses with mem_err.
//
// state      | meaning
// IDLE       | spi_req high, waiting for mem_req
// WAIT_VALID | transaction running, spi_* held stable
// GAP        | deselect time before the next launch
module spi_mem_bridge
    import spi_mem_pkg::*;
#(
    parameter int CS_GAP_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [23:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [1:0]  mem_size,
    input  logic        mem_unsigned,
    output logic [31:0] mem_rdata,
    output logic        mem_ready,
    output logic        mem_err,
    output logic        spi_req,
    output logic [23:0] spi_addr,
    output logic [31:0] spi_data_in,
    output logic [1:0]  spi_byte_mask,
    output logic        spi_write,
    input  logic [31:0] spi_data_out,
    input  logic        spi_busy,
    input  logic        spi_valid
);

    localparam logic [3:0] GAP_LOAD = 4'(CS_GAP_CYCLES - 1);

    bridge_state_t state, state_d;
    logic [3:0]    gap_cnt, gap_cnt_d;
    mem_size_t     size_q, size_d, req_size, fmt_size;
    logic          unsigned_q, unsigned_d;
    logic          spi_req_d, spi_write_d, mem_ready_d, mem_err_d;
    logic [23:0]   spi_addr_d;
    logic [31:0]   spi_data_in_d, mem_rdata_d;
    logic [1:0]    spi_byte_mask_d;
    logic [31:0]   fmt_wdata, fmt_rdata;
    logic          misaligned;

    assign req_size = mem_size_t'(mem_size);
    assign fmt_size = (state == IDLE) ? req_size : size_q;

`ifdef SPI_MEM_MISALIGN_TRAP_EN
    assign misaligned = is_misaligned(req_size, mem_addr[1:0]);
`else
    assign misaligned = 1'b0;
`endif

    spi_mem_lane_fmt u_lane_fmt (
        .size        (fmt_size),
        .is_unsigned (unsigned_q),
        .wdata       (mem_wdata),
        .spi_rdata   (spi_data_out),
        .spi_wdata   (fmt_wdata),
        .rdata       (fmt_rdata)
    );

    always_comb begin
        state_d         = state;
        gap_cnt_d       = gap_cnt;
        size_d          = size_q;
        unsigned_d      = unsigned_q;
        spi_req_d       = spi_req;
        spi_addr_d      = spi_addr;
        spi_data_in_d   = spi_data_in;
        spi_byte_mask_d = spi_byte_mask;
        spi_write_d     = spi_write;
        mem_rdata_d     = mem_rdata;
        mem_ready_d     = 1'b0;
        mem_err_d       = 1'b0;
        case (state)
            IDLE: begin
                // The ready pulse blocks re-accepting a request the core has not yet retired.
                if (mem_req && !mem_ready) begin
                    if (misaligned) begin
                        mem_ready_d = 1'b1;
                        mem_err_d   = 1'b1;
                        mem_rdata_d = '0;
                    end else begin
                        size_d          = req_size;
                        unsigned_d      = mem_unsigned;
                        spi_addr_d      = mem_addr;
                        spi_data_in_d   = fmt_wdata;
                        spi_byte_mask_d = size_to_mask(req_size);
                        spi_write_d     = mem_we;
                        spi_req_d       = 1'b0;
                        state_d         = WAIT_VALID;
                    end
                end
            end
            WAIT_VALID: begin
                if (spi_valid) begin
                    mem_rdata_d = spi_write ? '0 : fmt_rdata;
                    mem_ready_d = 1'b1;
                    spi_req_d   = 1'b1;
                    gap_cnt_d   = GAP_LOAD;
                    state_d     = GAP;
                end
            end
            GAP: begin
                if (!spi_valid && !spi_busy) begin
                    if (gap_cnt == 4'd0) begin
                        state_d = IDLE;
                    end else begin
                        gap_cnt_d = gap_cnt - 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            gap_cnt       <= '0;
            size_q        <= SIZE_BYTE;
            unsigned_q    <= 1'b0;
            spi_req       <= 1'b1;
            spi_addr      <= '0;
            spi_data_in   <= '0;
            spi_byte_mask <= '0;
            spi_write     <= 1'b0;
            mem_rdata     <= '0;
            mem_ready     <= 1'b0;
            mem_err       <= 1'b0;
        end else begin
            state         <= state_d;
            gap_cnt       <= gap_cnt_d;
            size_q        <= size_d;
            unsigned_q    <= unsigned_d;
            spi_req       <= spi_req_d;
            spi_addr      <= spi_addr_d;
            spi_data_in   <= spi_data_in_d;
            spi_byte_mask <= spi_byte_mask_d;
            spi_write     <= spi_write_d;
            mem_rdata     <= mem_rdata_d;
            mem_ready     <= mem_ready_d;
            mem_err       <= mem_err_d;
        end
    end

endmodule

// File: tb/tb_spi_mem_bridge.sv
// Self-checking bench for spi_mem_bridge with a behavioural SPI master and transaction model.
module tb_spi_mem_bridge;

    localparam int GAP = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_req = 1'b0;
    logic        mem_we = 1'b0;
    logic [23:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic [1:0]  mem_size = '0;
    logic        mem_unsigned = 1'b0;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        mem_err;
    logic        spi_req;
    logic [23:0] spi_addr;
    logic [31:0] spi_data_in;
    logic [1:0]  spi_byte_mask;
    logic        spi_write;
    logic [31:0] spi_data_out = '0;
    logic        spi_busy = 1'b0;
    logic        spi_valid = 1'b0;

    spi_mem_bridge #(.CS_GAP_CYCLES(GAP)) dut (
        .clk(clk), .reset(reset),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_size(mem_size), .mem_unsigned(mem_unsigned),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .mem_err(mem_err),
        .spi_req(spi_req), .spi_addr(spi_addr), .spi_data_in(spi_data_in),
        .spi_byte_mask(spi_byte_mask), .spi_write(spi_write),
        .spi_data_out(spi_data_out), .spi_busy(spi_busy), .spi_valid(spi_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] addr;
        logic [31:0] din;
        logic [1:0]  mask;
        logic        wr;
        logic [31:0] rdata;
        logic        err;
        bit          trap;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    logic [31:0] mst_data = '0;
    int   mst_lat = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    // CPU little-endian byte i goes to SPI byte slot i counted from the MSB.
    function automatic logic [31:0] m_wfmt(input logic [31:0] wd, input logic [1:0] sz);
        logic [31:0] r = '0;
        for (int i = 0; i < nbytes(sz); i++) r[31-8*i -: 8] = wd[8*i +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_rfmt(input logic [31:0] d, input logic [1:0] sz, input logic uns);
        logic [31:0] v = '0;
        int n = nbytes(sz);
        for (int i = 0; i < n; i++) v[8*i +: 8] = d[31-8*i -: 8];
        if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
        return v;
    endfunction

    // Behavioural SPI master: busy for mst_lat cycles, then a one-cycle valid.
    int mst_cnt = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (reset || spi_req) begin
                spi_busy = 1'b0; spi_valid = 1'b0; mst_cnt = 0;
            end else if (spi_valid) begin
                spi_valid = 1'b0;
            end else if (!spi_busy) begin
                spi_busy = 1'b1; mst_cnt = mst_lat;
            end else if (mst_cnt == 0) begin
                spi_busy = 1'b0; spi_valid = 1'b1; spi_data_out = mst_data;
            end else begin
                mst_cnt--;
            end
        end
    end

    // Transaction-level model of the bridge, compared every cycle just after the edge.
    bit m_inflight = 1'b0;
    bit exp_ready = 1'b0;
    bit prev_exp_ready = 1'b0;
    int since_ready = 1000;

    always @(posedge clk) begin
        #1;
        if (since_ready < 1000) since_ready++;
        exp_ready = 1'b0;
        if (reset) begin
            m_inflight = 1'b0;
            since_ready = 1000;
            exp_q.delete();
            chk("rst_spi_req", 32'(spi_req), 32'd1);
            chk("rst_mem_ready", 32'(mem_ready), 32'd0);
            chk("rst_mem_err", 32'(mem_err), 32'd0);
            chk("rst_mem_rdata", mem_rdata, 32'd0);
            chk("rst_spi_addr", 32'(spi_addr), 32'd0);
            chk("rst_spi_data_in", spi_data_in, 32'd0);
            chk("rst_spi_byte_mask", 32'(spi_byte_mask), 32'd0);
            chk("rst_spi_write", 32'(spi_write), 32'd0);
        end else begin
            if (m_inflight) begin
                if (spi_valid) begin
                    m_inflight = 1'b0;
                    exp_ready = 1'b1;
                    since_ready = 0;
                end
            end else if (mem_req && since_ready >= GAP + 1 && exp_q.size() > 0 && !prev_exp_ready) begin
                if (exp_q[0].trap) exp_ready = 1'b1;
                else m_inflight = 1'b1;
            end
            chk("spi_req", 32'(spi_req), 32'(!m_inflight));
            chk("mem_ready", 32'(mem_ready), 32'(exp_ready));
            if (m_inflight && exp_q.size() > 0) begin
                chk("spi_addr", 32'(spi_addr), 32'(exp_q[0].addr));
                chk("spi_data_in", spi_data_in, exp_q[0].din);
                chk("spi_byte_mask", 32'(spi_byte_mask), 32'(exp_q[0].mask));
                chk("spi_write", 32'(spi_write), 32'(exp_q[0].wr));
            end
            if (exp_ready && exp_q.size() > 0) begin
                chk("mem_rdata", mem_rdata, exp_q[0].rdata);
                chk("mem_err", 32'(mem_err), 32'(exp_q[0].err));
                void'(exp_q.pop_front());
            end
        end
        prev_exp_ready = exp_ready;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic exp_t make_exp(input bit we, input logic [23:0] addr, input logic [31:0] wd,
                                      input logic [1:0] sz, input bit uns, input logic [31:0] dout);
        exp_t e;
        int n = nbytes(sz);
        e.addr  = addr;
        e.din   = m_wfmt(wd, sz);
        e.mask  = (n == 1) ? 2'b00 : (n == 2) ? 2'b01 : 2'b10;
        e.wr    = we;
        e.rdata = we ? 32'd0 : m_rfmt(dout, sz, uns);
        e.err   = 1'b0;
        e.trap  = 1'b0;
        return e;
    endfunction

    // Issues one request and holds mem_req until mem_ready; caller may chain directly.
    task automatic run_txn(input bit we, input logic [23:0] addr, input logic [31:0] wd,
                           input logic [1:0] sz, input bit uns, input logic [31:0] dout,
                           input int lat, input bit lit, input logic [31:0] lit_din,
                           input logic [31:0] lit_rd);
        exp_t e;
        int   n;
        e = make_exp(we, addr, wd, sz, uns, dout);
        if (lit) begin
            chk("model_din", e.din, lit_din);
            chk("model_rdata", e.rdata, lit_rd);
            e.din = lit_din;
            e.rdata = lit_rd;
        end
`ifdef SPI_MEM_MISALIGN_TRAP_EN
        if ((nbytes(sz) == 2 && addr[0]) || (nbytes(sz) == 4 && addr[1:0] != 2'b00)) begin
            e.trap = 1'b1; e.err = 1'b1; e.rdata = 32'd0;
        end
`endif
        mst_data = dout;
        mst_lat = lat;
        exp_q.push_back(e);
        mem_req = 1'b1; mem_we = we; mem_addr = addr; mem_wdata = wd;
        mem_size = sz; mem_unsigned = uns;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mem_ready && n < 100);
        if (!mem_ready) begin
            n_chk++; n_fail++;
            $display("FAIL ready_timeout: no mem_ready after %0d cycles at %0t", n, $time);
        end
        mem_req = 1'b0;
    endtask

    initial begin
        int aborted_wait;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        idle(2);

        run_txn(1'b1, 24'h000100, 32'h11223344, 2'b10, 1'b0, 32'h0, 2, 1'b1, 32'h44332211, 32'h0);
        idle(4);
        run_txn(1'b0, 24'h000040, 32'h0, 2'b00, 1'b0, 32'h80AABBCC, 1, 1'b1, 32'h0, 32'hFFFFFF80);
        idle(4);
        run_txn(1'b0, 24'h000042, 32'h0, 2'b01, 1'b1, 32'h3412FFFF, 0, 1'b1, 32'h0, 32'h00001234);
        idle(4);
        run_txn(1'b0, 24'h000044, 32'h0, 2'b10, 1'b0, 32'h3412FFFF, 3, 1'b1, 32'h0, 32'hFFFF1234);

        // Back-to-back: mem_req never drops, launch spacing is set by the deselect gap.
        run_txn(1'b1, 24'h000200, 32'hA1B2C3D4, 2'b01, 1'b0, 32'h0, 1, 1'b1, 32'hD4C30000, 32'h0);
        run_txn(1'b0, 24'h000204, 32'h0, 2'b11, 1'b1, 32'h01020304, 0, 1'b1, 32'h0, 32'h04030201);
        idle(5);

        // Reset while the master is still shifting.
        mst_lat = 10;
        mst_data = 32'h55555555;
        exp_q.push_back(make_exp(1'b0, 24'h000300, 32'h0, 2'b10, 1'b0, 32'h55555555));
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 24'h000300; mem_size = 2'b10; mem_unsigned = 1'b0;
        aborted_wait = 0;
        while (spi_req && aborted_wait < 20) begin
            @(negedge clk);
            aborted_wait++;
        end
        idle(2);
        reset = 1'b1; mem_req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        idle(15);
        run_txn(1'b0, 24'h000310, 32'h0, 2'b00, 1'b1, 32'hC3000000, 1, 1'b1, 32'h0, 32'h000000C3);
        idle(4);

        // Misaligned word load: trapped with the macro, forwarded unchanged without it.
`ifdef SPI_MEM_MISALIGN_TRAP_EN
        run_txn(1'b0, 24'h000102, 32'h0, 2'b10, 1'b0, 32'hDEADBEEF, 1, 1'b1, 32'h0, 32'hEFBEADDE);
`else
        run_txn(1'b0, 24'h000102, 32'h0, 2'b10, 1'b0, 32'hDEADBEEF, 1, 1'b1, 32'h0, 32'hEFBEADDE);
`endif
        idle(4);

        for (int i = 0; i < 60; i++) begin
            run_txn(1'($urandom_range(0, 1)), 24'($urandom), $urandom, 2'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 5), 1'b0, 32'h0, 32'h0);
            idle($urandom_range(0, 4));
        end
        idle(8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish by %0t", $time);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
        $fatal(1);
    end

endmodule
